// File: rtl/firebird7_in_gate2_tessent_sol_monitor_ctrl.sv
// firebird7_in_gate2_tessent_sol_monitor_ctrl: gate2 SOL toggle monitor feeding the status TDR.
// Define FIREBIRD7_SOL_MON_AUTO_RESTART_EN for back-to-back windows while mon_enable is held.
module firebird7_in_gate2_tessent_sol_monitor_ctrl #(
    parameter int CNT_WIDTH   = 15,
    parameter int WIN_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 ijtag_tck,
    input  logic                 ijtag_reset,
    input  logic                 sol_in,
    input  logic                 mon_enable,
    input  logic                 mon_clear,
    input  logic [WIN_WIDTH-1:0] mon_window,
    input  logic                 status_capture,
    output logic                 sol_out,
    output logic                 sol_tog_status,
    output logic [CNT_WIDTH-1:0] sol_cnt_status,
    output logic                 mon_busy,
    output logic                 mon_done
);
    typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;
    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sol_d;
    logic                   inc;
    logic                   pending;
    logic [WIN_WIDTH-1:0]   win_cnt;
    logic [CNT_WIDTH-1:0]   live_cnt, live_nx, pend_cnt;
    assign sol_out = sync_q[SYNC_STAGES-1];
    assign inc     = (sol_out ^ sol_d) && !(&live_cnt);
    assign live_nx = live_cnt + CNT_WIDTH'(inc);
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = mon_enable ? ARM : IDLE;
            ARM:   state_nx = mon_enable ? COUNT : IDLE;
            COUNT: state_nx = !mon_enable ? IDLE : (win_cnt == '0) ? DONE : COUNT;
`ifdef FIREBIRD7_SOL_MON_AUTO_RESTART_EN
            DONE:  state_nx = mon_enable ? ARM : IDLE;
`else
            DONE:  state_nx = mon_enable ? DONE : IDLE;
`endif
            default: state_nx = IDLE;
        endcase
        if (mon_clear) state_nx = IDLE;
    end
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            state          <= IDLE;
            sync_q         <= '0;
            sol_d          <= 1'b0;
            win_cnt        <= '0;
            live_cnt       <= '0;
            pend_cnt       <= '0;
            pending        <= 1'b0;
            sol_cnt_status <= '0;
            sol_tog_status <= 1'b0;
            mon_busy       <= 1'b0;
            mon_done       <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], sol_in};
            sol_d    <= sol_out;
            state    <= state_nx;
            mon_busy <= (state_nx == ARM) || (state_nx == COUNT);
            mon_done <= (state_nx == DONE);
            if (mon_clear) begin
                live_cnt       <= '0;
                pend_cnt       <= '0;
                pending        <= 1'b0;
                sol_cnt_status <= '0;
                sol_tog_status <= 1'b0;
            end else begin
                if (state == ARM) begin
                    live_cnt <= '0;
                    win_cnt  <= mon_window;
                end
                if (state == COUNT) begin
                    live_cnt <= live_nx;
                    win_cnt  <= win_cnt - WIN_WIDTH'(1);
                end
                // Snapshot the final count so a deferred publish survives the next ARM.
                if (state == COUNT && state_nx == DONE) begin
                    pending  <= 1'b1;
                    pend_cnt <= live_nx;
                end else if (pending && !status_capture) begin
                    pending        <= 1'b0;
                    sol_cnt_status <= pend_cnt;
                    sol_tog_status <= (pend_cnt != '0);
                end
            end
        end
    end
endmodule
